qr_result_packer: RTL and testbench
===================================

QR_RESULT_PACKER -- requirements
Module: qr_result_packer

Interface
REQ-001 Parameter DEPTH, default 32, byte capacity of the frame buffer; power of two, range 4..64.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port srstn  input  1  asynchronous active-low reset.
REQ-004 Port decode_valid  input  1  one-cycle strobe: decode_jis8_code holds a decoded byte.
REQ-005 Port decode_jis8_code  input  8  decoded JIS8 byte.
REQ-006 Port qr_decode_finish  input  1  one-cycle strobe: current QR symbol fully decoded.
REQ-007 Port out_valid  output  1  out_data is presented.
REQ-008 Port out_data  output  8  frame byte: length first, then payload.
REQ-009 Port out_last  output  1  marks the final byte of a frame.
REQ-010 Port out_ready  input  1  downstream accepts; a transfer occurs when out_valid and out_ready are both 1.
REQ-011 Port busy  output  1  high in SEND_LEN/SEND_DATA/SEND_CHK.
REQ-012 Port overflow  output  1  sticky flag: at least one byte was dropped in the current or last frame.

Function
REQ-013 FSM states: COLLECT (reset state), SEND_LEN, SEND_DATA, SEND_CHK.
- Write pointer/count, read pointer, and overflow are registered; out_* are driven from registered state and buffer contents, with no combinational path from decode inputs.
REQ-014 COLLECT: decode_valid with count<DEPTH -> byte written at count; count increments.
- Count is $clog2(DEPTH)+1 bits wide.
REQ-015 COLLECT: decode_valid with count==DEPTH -> byte dropped; overflow set to 1.
REQ-016 COLLECT: qr_decode_finish -> next state SEND_LEN; count is frozen as the frame length.
REQ-017 Same-cycle decode_valid and qr_decode_finish -> the byte is stored (subject to REQ-015) before the length is frozen.
REQ-018 SEND_LEN: out_valid=1, out_data=count (zero-extended to 8 bits), out_last=1 only when count==0 and the checksum feature is absent.
- On handshake: go to SEND_DATA if count>0, else go to SEND_CHK (feature present) or COLLECT.
REQ-019 SEND_DATA: out_data=buffer[rd_ptr], with rd_ptr starting at 0.
- Each handshake increments rd_ptr.
- out_last=1 on byte count-1 when the checksum feature is absent.
- After the last byte: go to SEND_CHK (feature present) or COLLECT.
REQ-020 out_valid/out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 decode_valid while busy -> byte dropped; overflow set.
- qr_decode_finish while busy -> ignored.
REQ-022 Entering COLLECT from a send state clears count and rd_ptr.
- overflow clears on the first decode_valid accepted in COLLECT, not before, so software can sample it after a frame.
REQ-023 Latency: out_valid rises on the cycle after qr_decode_finish is sampled.
- With out_ready held at 1, a frame of N bytes completes in N+1 cycles (N+2 with the checksum feature).

Reset
REQ-024 srstn=0 asynchronously forces state=COLLECT, count=0, rd_ptr=0, overflow=0, out_valid=0, out_last=0, out_data=0, busy=0.
- Buffer contents are not reset.
REQ-025 Reset asserted mid-frame aborts the frame with no partial completion.
- The first byte after release is stored at index 0.

Configuration
REQ-026 Macro QR_PACK_CHECKSUM_EN.
- Defined: a running XOR of all stored payload bytes (initialised to 0x00 in COLLECT) is sent in SEND_CHK as the final byte with out_last=1.
- Undefined: the SEND_CHK state and the XOR register do not exist, and out_last marks the last length or payload byte.

Structure
REQ-027 Shared package qr_pkg SHALL hold the state enum type, the JIS8 byte typedef, and the constant QR_MAX_BYTES=32 (default for DEPTH).
REQ-028 One sub-module qr_byte_ram (DEPTH x 8, one synchronous write port, one asynchronous read port) SHALL hold the buffer.
- All control logic stays in qr_result_packer.

Verification
REQ-029 Bytes 0x48,0x49 then finish, out_ready=1 -> out_data 0x02,0x48,0x49, out_last on 0x49; with the checksum feature, a fourth byte 0x01 with out_last.
REQ-030 Finish with no bytes -> a single byte 0x00 with out_last=1 (checksum feature absent); with the feature, 0x00 then 0x00 with last.
REQ-031 33 strobes with DEPTH=32 -> length 0x20, overflow=1 through the frame, cleared by the next frame's first byte.
REQ-032 out_ready toggled 1,0,0,1 during SEND_DATA -> no byte is duplicated or skipped, and out_data holds stable while stalled.
REQ-033 decode_valid with finish in the same cycle for the 3rd byte -> length 0x03, and that byte is the last payload byte.
REQ-034 srstn pulsed low during SEND_DATA -> out_valid=0 immediately; a new frame of 1 byte after release emits 0x01 and that byte only.

Source files
------------

// File: rtl/qr_pkg.sv
// Shared types and constants for the QR result packer.
// QR_PACK_CHECKSUM_EN adds the SEND_CHK state to the state type.
package qr_pkg;

    localparam int QR_MAX_BYTES = 32;

    typedef logic [7:0] jis8_t;

`ifdef QR_PACK_CHECKSUM_EN
    typedef enum logic [1:0] {
        COLLECT   = 2'd0,
        SEND_LEN  = 2'd1,
        SEND_DATA = 2'd2,
        SEND_CHK  = 2'd3
    } qr_state_t;
`else
    typedef enum logic [1:0] {
        COLLECT   = 2'd0,
        SEND_LEN  = 2'd1,
        SEND_DATA = 2'd2
    } qr_state_t;
`endif

endpackage

// File: rtl/qr_byte_ram.sv
// Frame byte buffer: DEPTH x 8, one synchronous write port, one asynchronous read port.
// Contents are never reset.
module qr_byte_ram
    import qr_pkg::*;
#(
    parameter int DEPTH = QR_MAX_BYTES,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  jis8_t         wdata,
    input  logic [AW-1:0] raddr,
    output jis8_t         rdata
);

    jis8_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/qr_result_packer.sv
// Collects decoded JIS8 bytes of one QR symbol and emits them as a length-prefixed frame.
// Optional trailing XOR checksum byte when QR_PACK_CHECKSUM_EN is defined.
module qr_result_packer
    import qr_pkg::*;
#(
    parameter int DEPTH = QR_MAX_BYTES
) (
    input  logic       clk,
    input  logic       srstn,
    input  logic       decode_valid,
    input  jis8_t      decode_jis8_code,
    input  logic       qr_decode_finish,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef QR_PACK_CHECKSUM_EN
    localparam qr_state_t TAIL_STATE = SEND_CHK;
`else
    localparam qr_state_t TAIL_STATE = COLLECT;
`endif

    qr_state_t       state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [CW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic            overflow_reg, overflow_next;
    logic            wr_en;
    jis8_t           rd_data;
`ifdef QR_PACK_CHECKSUM_EN
    jis8_t           chk_reg, chk_next;
`endif

    qr_byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (count_reg[AW-1:0]),
        .wdata (decode_jis8_code),
        .raddr (rd_ptr_reg[AW-1:0]),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_reg    <= COLLECT;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
`ifdef QR_PACK_CHECKSUM_EN
            chk_reg      <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            rd_ptr_reg   <= rd_ptr_next;
            overflow_reg <= overflow_next;
`ifdef QR_PACK_CHECKSUM_EN
            chk_reg      <= chk_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        rd_ptr_next   = rd_ptr_reg;
        overflow_next = overflow_reg;
        wr_en         = 1'b0;
`ifdef QR_PACK_CHECKSUM_EN
        chk_next      = chk_reg;
`endif
        case (state_reg)
            COLLECT: begin
                // A byte arriving with finish is stored first, so the frozen length includes it.
                if (decode_valid) begin
                    if (count_reg < CW'(DEPTH)) begin
                        wr_en         = 1'b1;
                        count_next    = count_reg + CW'(1);
                        overflow_next = 1'b0;
`ifdef QR_PACK_CHECKSUM_EN
                        chk_next      = chk_reg ^ decode_jis8_code;
`endif
                    end else begin
                        overflow_next = 1'b1;
                    end
                end
                if (qr_decode_finish) begin
                    state_next = SEND_LEN;
                end
            end
            SEND_LEN: begin
                if (out_ready) begin
                    state_next = (count_reg != '0) ? SEND_DATA : TAIL_STATE;
                end
            end
            SEND_DATA: begin
                if (out_ready) begin
                    rd_ptr_next = rd_ptr_reg + CW'(1);
                    if (rd_ptr_reg == count_reg - CW'(1)) begin
                        state_next = TAIL_STATE;
                    end
                end
            end
`ifdef QR_PACK_CHECKSUM_EN
            SEND_CHK: begin
                if (out_ready) begin
                    state_next = COLLECT;
                end
            end
`endif
            default: state_next = COLLECT;
        endcase

        // Bytes arriving while a frame is being sent are lost; flag it.
        if (state_reg != COLLECT && decode_valid) begin
            overflow_next = 1'b1;
        end
        if (state_reg != COLLECT && state_next == COLLECT) begin
            count_next  = '0;
            rd_ptr_next = '0;
`ifdef QR_PACK_CHECKSUM_EN
            chk_next    = '0;
`endif
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        case (state_reg)
            SEND_LEN: begin
                out_valid = 1'b1;
                out_data  = 8'(count_reg);
`ifndef QR_PACK_CHECKSUM_EN
                out_last  = (count_reg == '0);
`endif
            end
            SEND_DATA: begin
                out_valid = 1'b1;
                out_data  = rd_data;
`ifndef QR_PACK_CHECKSUM_EN
                out_last  = (rd_ptr_reg == count_reg - CW'(1));
`endif
            end
`ifdef QR_PACK_CHECKSUM_EN
            SEND_CHK: begin
                out_valid = 1'b1;
                out_data  = chk_reg;
                out_last  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign busy     = out_valid;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_qr_result_packer.sv
// Randomised self-checking bench for qr_result_packer against a frame-level reference model.
// Honours QR_PACK_CHECKSUM_EN the same way as the design.
module tb_qr_result_packer;

    localparam int DEPTH = 32;
`ifdef QR_PACK_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       srstn;
    logic       decode_valid;
    logic [7:0] decode_jis8_code;
    logic       qr_decode_finish;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       busy;
    logic       overflow;

    int vectors     = 0;
    int miscompares = 0;

    byte unsigned got_d[$];
    bit           got_l[$];
    byte unsigned exp_d[$];
    bit           exp_l[$];

    qr_result_packer #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .srstn            (srstn),
        .decode_valid     (decode_valid),
        .decode_jis8_code (decode_jis8_code),
        .qr_decode_finish (qr_decode_finish),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_last         (out_last),
        .out_ready        (out_ready),
        .busy             (busy),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    // Reference: length byte (capped at DEPTH), stored payload, optional XOR; last flag on the final byte.
    task automatic model_frame(input byte unsigned pl[$]);
        int n;
        byte unsigned x;
        n = (pl.size() > DEPTH) ? DEPTH : pl.size();
        x = 8'h00;
        exp_d.delete();
        exp_l.delete();
        exp_d.push_back(byte'(n));
        for (int i = 0; i < n; i++) begin
            exp_d.push_back(pl[i]);
            x ^= pl[i];
        end
        if (CHK_EN) exp_d.push_back(x);
        for (int i = 0; i < exp_d.size(); i++) exp_l.push_back(i == exp_d.size() - 1);
    endtask

    task automatic push(input logic [7:0] b, input bit fin);
        decode_valid     = 1'b1;
        decode_jis8_code = b;
        qr_decode_finish = fin;
        @(negedge clk);
        decode_valid     = 1'b0;
        qr_decode_finish = 1'b0;
    endtask

    task automatic finish_only();
        qr_decode_finish = 1'b1;
        @(negedge clk);
        qr_decode_finish = 1'b0;
    endtask

    task automatic send_payload(input byte unsigned pl[$], input bit fin_last);
        for (int i = 0; i < pl.size(); i++) push(pl[i], fin_last && (i == pl.size() - 1));
        if (!fin_last || pl.size() == 0) finish_only();
    endtask

    // Collects one frame at negedges; mode 0 holds out_ready high, mode 1 randomises it.
    task automatic capture(input int mode, output int cycles, output bit timeout);
        got_d.delete();
        got_l.delete();
        cycles  = 0;
        timeout = 1'b1;
        for (int c = 0; c < 4 * DEPTH + 20; c++) begin
            out_ready = (mode == 0) ? 1'b1 : 1'(($urandom % 4) != 0);
            cycles++;
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
                if (out_last) timeout = 1'b0;
            end
            @(negedge clk);
            if (!timeout) break;
        end
        out_ready = 1'b0;
        $display("frame: %0d bytes in %0d cycles, first=%02h", got_d.size(), cycles,
                 (got_d.size() > 0) ? got_d[0] : 8'h00);
    endtask

    task automatic test_reset();
        srstn = 1'b0; decode_valid = 1'b0; decode_jis8_code = '0;
        qr_decode_finish = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %02h exp 00", out_data); end
        vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_last got %b exp 0", out_last); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        srstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_hi();
        byte unsigned pl[$];
        int cyc; bit to;
        pl = '{8'h48, 8'h49};
        model_frame(pl);
        send_payload(pl, 1'b0);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL hi_latency valid got %b exp 1", out_valid); end
        capture(0, cyc, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL hi_timeout got %b exp 0", to); end
        vectors++; if (cyc !== exp_d.size()) begin miscompares++; $display("FAIL hi_cycles got %0d exp %0d", cyc, exp_d.size()); end
        vectors++;
        if (got_d.size() != exp_d.size()) begin miscompares++; $display("FAIL hi_size got %0d exp %0d", got_d.size(), exp_d.size()); end
        else for (int i = 0; i < exp_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                miscompares++; $display("FAIL hi_byte%0d got %02h/%b exp %02h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL hi_idle valid got %b exp 0", out_valid); end
    endtask

    task automatic test_empty();
        byte unsigned pl[$];
        int cyc; bit to;
        model_frame(pl);
        send_payload(pl, 1'b0);
        capture(0, cyc, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL empty_timeout got %b exp 0", to); end
        vectors++;
        if (got_d.size() != exp_d.size()) begin miscompares++; $display("FAIL empty_size got %0d exp %0d", got_d.size(), exp_d.size()); end
        else for (int i = 0; i < exp_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                miscompares++; $display("FAIL empty_byte%0d got %02h/%b exp %02h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_overflow();
        byte unsigned pl[$];
        int cyc; bit to;
        for (int i = 0; i < DEPTH + 1; i++) pl.push_back(byte'($urandom));
        model_frame(pl);
        send_payload(pl, 1'b0);
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_start got %b exp 1", overflow); end
        capture(0, cyc, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL ovf_timeout got %b exp 0", to); end
        vectors++;
        if (got_d.size() != exp_d.size()) begin miscompares++; $display("FAIL ovf_size got %0d exp %0d", got_d.size(), exp_d.size()); end
        else for (int i = 0; i < exp_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                miscompares++; $display("FAIL ovf_byte%0d got %02h/%b exp %02h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_after got %b exp 1", overflow); end
        pl.delete();
        pl.push_back(byte'($urandom));
        model_frame(pl);
        push(pl[0], 1'b0);
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear got %b exp 0", overflow); end
        finish_only();
        capture(0, cyc, to);
        vectors++; if (got_d.size() != exp_d.size() || got_d[got_d.size()-1] !== exp_d[exp_d.size()-1]) begin
            miscompares++; $display("FAIL ovf_next got %0d bytes exp %0d", got_d.size(), exp_d.size());
        end
    endtask

    task automatic test_stall();
        byte unsigned pl[$];
        logic [3:0] pat;
        logic [7:0] prev_d;
        logic       prev_l;
        bit prev_stall, done;
        int k;
        pat = 4'b1001;
        for (int i = 0; i < 4; i++) pl.push_back(byte'($urandom));
        model_frame(pl);
        send_payload(pl, 1'b0);
        got_d.delete(); got_l.delete();
        prev_stall = 1'b0; done = 1'b0; k = 0; prev_d = '0; prev_l = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (got_d.size() == 0) out_ready = 1'b1;
            else begin out_ready = pat[k % 4]; k++; end
            if (prev_stall) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l) begin
                    miscompares++; $display("FAIL stall_hold got %b/%02h/%b exp 1/%02h/%b", out_valid, out_data, out_last, prev_d, prev_l);
                end
            end
            if (out_valid && out_ready) begin
                got_d.push_back(out_data); got_l.push_back(out_last);
                if (out_last) done = 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data; prev_l = out_last;
            @(negedge clk);
        end
        out_ready = 1'b0;
        $display("frame: %0d bytes under stall pattern", got_d.size());
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL stall_timeout got %b exp 1", done); end
        vectors++;
        if (got_d.size() != exp_d.size()) begin miscompares++; $display("FAIL stall_size got %0d exp %0d", got_d.size(), exp_d.size()); end
        else for (int i = 0; i < exp_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                miscompares++; $display("FAIL stall_byte%0d got %02h/%b exp %02h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_same_cycle();
        byte unsigned pl[$];
        int cyc; bit to;
        for (int i = 0; i < 3; i++) pl.push_back(byte'($urandom));
        model_frame(pl);
        send_payload(pl, 1'b1);
        capture(0, cyc, to);
        vectors++;
        if (got_d.size() != exp_d.size()) begin miscompares++; $display("FAIL same_size got %0d exp %0d", got_d.size(), exp_d.size()); end
        else for (int i = 0; i < exp_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                miscompares++; $display("FAIL same_byte%0d got %02h/%b exp %02h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_busy_drop();
        byte unsigned pl[$];
        int cyc; bit to;
        for (int i = 0; i < 2; i++) pl.push_back(byte'($urandom));
        model_frame(pl);
        send_payload(pl, 1'b0);
        out_ready = 1'b0;
        push(byte'($urandom), 1'b1);
        vectors++; if (out_valid !== 1'b1 || out_data !== exp_d[0]) begin
            miscompares++; $display("FAIL busy_hold got %b/%02h exp 1/%02h", out_valid, out_data, exp_d[0]);
        end
        capture(1, cyc, to);
        vectors++;
        if (got_d.size() != exp_d.size()) begin miscompares++; $display("FAIL busy_size got %0d exp %0d", got_d.size(), exp_d.size()); end
        else for (int i = 0; i < exp_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                miscompares++; $display("FAIL busy_byte%0d got %02h/%b exp %02h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL busy_ovf got %b exp 1", overflow); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL busy_finish_ignored valid got %b exp 0", out_valid); end
        push(8'h5a, 1'b1);
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL busy_ovf_clear got %b exp 0", overflow); end
        capture(0, cyc, to);
    endtask

    task automatic test_reset_mid();
        byte unsigned pl[$];
        int cyc; bit to;
        for (int i = 0; i < 5; i++) pl.push_back(byte'($urandom));
        send_payload(pl, 1'b0);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        srstn = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_valid got %b/%b exp 0/0", out_valid, busy);
        end
        @(negedge clk);
        srstn = 1'b1;
        @(negedge clk);
        pl.delete();
        pl.push_back(byte'($urandom));
        model_frame(pl);
        send_payload(pl, 1'b1);
        capture(0, cyc, to);
        vectors++;
        if (got_d.size() != exp_d.size()) begin miscompares++; $display("FAIL rstmid_size got %0d exp %0d", got_d.size(), exp_d.size()); end
        else for (int i = 0; i < exp_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                miscompares++; $display("FAIL rstmid_byte%0d got %02h/%b exp %02h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_random();
        byte unsigned pl[$];
        int cyc, n; bit to, fin_last, model_ovf;
        model_ovf = 1'b0;
        for (int f = 0; f < 25; f++) begin
            n = $urandom_range(0, DEPTH + 3);
            fin_last = 1'($urandom % 2);
            pl.delete();
            for (int i = 0; i < n; i++) pl.push_back(byte'($urandom));
            if (n > 0) model_ovf = (n > DEPTH);
            model_frame(pl);
            send_payload(pl, fin_last);
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_latency got %b exp 1", f, out_valid); end
            capture(1, cyc, to);
            vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_timeout got %b exp 0", f, to); end
            vectors++;
            if (got_d.size() != exp_d.size()) begin miscompares++; $display("FAIL rnd%0d_size got %0d exp %0d", f, got_d.size(), exp_d.size()); end
            else for (int i = 0; i < exp_d.size(); i++) begin
                vectors++;
                if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                    miscompares++; $display("FAIL rnd%0d_byte%0d got %02h/%b exp %02h/%b", f, i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                end
            end
            vectors++; if (overflow !== model_ovf) begin miscompares++; $display("FAIL rnd%0d_ovf got %b exp %b", f, overflow, model_ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_hi();
        test_empty();
        test_overflow();
        test_stall();
        test_same_cycle();
        test_busy_drop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d vectors, required completion", vectors);
        $fatal(1);
    end

endmodule
